pit_count_mc: RTL

Multi-channel programmable interval timer counter bank: NUM_CH independent modulo-N counters share one prescaler tick (prescale_out). Each channel has periodic or one-shot mode. Each channel has a shadow modulus register, so a modulus written mid-count takes effect only at rollover or while the channel is disabled. Sits between the PIT prescaler and the register/interrupt block, and replaces the single-channel counter.

---
 rtl/pit_count_mc_if.sv | 28 ++
 rtl/pit_count_mc.sv | 107 ++++++++++
 2 files changed

// File: rtl/pit_count_mc_if.sv
// Signal bundle between the PIT register/prescaler side and the multi-channel counter bank.
// Master drives the controls; the counter bank (slave) returns counts, flags and pulses.
interface pit_count_mc_if #(
  parameter int COUNT_SIZE = 16,
  parameter int NUM_CH     = 4
);
  logic                         sync_reset;
  logic                         prescale_out;
  logic [NUM_CH-1:0]            ch_enable;
  logic [NUM_CH-1:0]            ch_oneshot;
  logic [NUM_CH-1:0]            pit_flg_clr;
  logic [NUM_CH*COUNT_SIZE-1:0] mod_value;
  logic [NUM_CH*COUNT_SIZE-1:0] cnt_n;
  logic [NUM_CH-1:0]            cnt_flag_o;
  logic [NUM_CH-1:0]            pit_o;
  logic [NUM_CH-1:0]            ch_active_o;
  logic                         irq_o;

  modport master (
    output sync_reset, prescale_out, ch_enable, ch_oneshot, pit_flg_clr, mod_value,
    input  cnt_n, cnt_flag_o, pit_o, ch_active_o, irq_o
  );

  modport slave (
    input  sync_reset, prescale_out, ch_enable, ch_oneshot, pit_flg_clr, mod_value,
    output cnt_n, cnt_flag_o, pit_o, ch_active_o, irq_o
  );
endinterface

// File: rtl/pit_count_mc.sv
// Bank of NUM_CH independent modulo-N interval counters sharing one prescaler tick.
// Each channel runs periodic or one-shot and latches its modulus only at rollover or while disabled.
module pit_count_mc #(
  parameter int COUNT_SIZE = 16,
  parameter int NUM_CH     = 4
) (
  input  logic           bus_clk,
  input  logic           async_rst_b,
  pit_count_mc_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                             r_state [NUM_CH];
  logic [NUM_CH-1:0][COUNT_SIZE-1:0]  r_cnt;
  logic [NUM_CH-1:0][COUNT_SIZE-1:0]  r_shadow;
  logic [NUM_CH-1:0]                  r_flag;
  logic [NUM_CH-1:0]                  r_pit;
  logic [NUM_CH-1:0]                  r_active;
  logic                               r_irq;

  logic [NUM_CH-1:0][COUNT_SIZE-1:0]  w_mod;
  logic [NUM_CH-1:0]                  w_no_div;
  logic [NUM_CH-1:0]                  w_roll;
  logic [NUM_CH-1:0]                  w_flag_nxt;

  assign w_mod = bus.mod_value;

  always_comb begin
    w_no_div   = '0;
    w_roll     = '0;
    w_flag_nxt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_no_div[i] = (r_shadow[i] == '0) || (r_shadow[i] == COUNT_SIZE'(1));
      w_roll[i]   = (r_state[i] == ST_RUN) && bus.prescale_out &&
                    ((r_cnt[i] == r_shadow[i]) || w_no_div[i]);
      // Set beats a coincident clear so no rollover event is lost.
      if (!bus.ch_enable[i])      w_flag_nxt[i] = 1'b0;
      else if (w_roll[i])         w_flag_nxt[i] = 1'b1;
      else if (bus.pit_flg_clr[i]) w_flag_nxt[i] = 1'b0;
      else                        w_flag_nxt[i] = r_flag[i];
    end
  end

  always_ff @(posedge bus_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_state[i]  <= ST_IDLE;
        r_cnt[i]    <= COUNT_SIZE'(1);
        r_shadow[i] <= '0;
      end
      r_flag   <= '0;
      r_pit    <= '0;
      r_active <= '0;
      r_irq    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!bus.ch_enable[i] || w_roll[i]) r_shadow[i] <= w_mod[i];

        if (!bus.ch_enable[i]) begin
          r_state[i]  <= ST_IDLE;
          r_active[i] <= 1'b0;
        end else begin
          case (r_state[i])
            ST_IDLE: begin
              r_state[i]  <= ST_RUN;
              r_active[i] <= 1'b1;
            end
            ST_RUN: begin
              if (w_roll[i] && bus.ch_oneshot[i]) begin
                r_state[i]  <= ST_DONE;
                r_active[i] <= 1'b0;
              end else begin
                r_active[i] <= 1'b1;
              end
            end
            default: begin
              r_state[i]  <= ST_DONE;
              r_active[i] <= 1'b0;
            end
          endcase
        end

        if ((r_state[i] != ST_RUN) || !bus.ch_enable[i] || w_roll[i] || w_no_div[i])
          r_cnt[i] <= COUNT_SIZE'(1);
        else if (bus.prescale_out)
          r_cnt[i] <= r_cnt[i] + COUNT_SIZE'(1);

        r_pit[i] <= w_roll[i] && !bus.sync_reset;
      end
      r_flag <= w_flag_nxt;
      // Uses next-state flags so irq_o updates on the same edge as cnt_flag_o.
      r_irq  <= |w_flag_nxt;
    end
  end

  assign bus.cnt_n       = r_cnt;
  assign bus.cnt_flag_o  = r_flag;
  assign bus.pit_o       = r_pit;
  assign bus.ch_active_o = r_active;
  assign bus.irq_o       = r_irq;

endmodule
